// File: rtl/sseg_scan_mux_if.sv
// Bundle between a seven-segment scan controller and whatever feeds it.
//   master : drives load/digits_in/dp_in/en_in, observes the display outputs
//   slave  : the scanner itself
// Signals:
//   load       1-cycle strobe capturing digits_in/dp_in/en_in into pending regs
//   digits_in  4 bits per digit, digit 0 in the low nibble (rightmost digit)
//   dp_in      decimal point per digit, 1 = lit
//   en_in      digit enable, 0 = digit dark for its whole slot
//   bin_out    code of the digit currently scanned
//   dp_n       active-low decimal point
//   an_n       active-low anode selects
//   digit_idx  index of the current slot
//   frame_done 1-cycle pulse on the frame wrap
//   pending    loaded data waiting for the next frame commit
interface sseg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   en_in;
  logic [3:0]              bin_out;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  logic                    pending;

  modport master (
    output load, digits_in, dp_in, en_in,
    input  bin_out, dp_n, an_n, digit_idx, frame_done, pending
  );

  modport slave (
    input  load, digits_in, dp_in, en_in,
    output bin_out, dp_n, an_n, digit_idx, frame_done, pending
  );
endinterface

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
// Each digit gets a slot of PRESCALE clocks; the first BLANK clocks of a slot keep
// every anode off so the previous digit's segments cannot ghost onto the new one.
// Loaded digit data waits in pending registers and is committed at the frame wrap,
// so a frame never shows a mix of old and new digits.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sseg_scan_mux_if slave modport (load/data in, scan outputs out)
module sseg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  sseg_scan_mux_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
  // With no blanking gap every slot starts directly in SHOW.
  localparam phase_t PH_RST = (BLANK == 0) ? PH_SHOW : PH_BLANK;

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  phase_t                  phase;
  logic                    nxt_blank;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   an_show;

  logic [4*NUM_DIGITS-1:0] disp_dig, pend_dig;
  logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   disp_en, pend_en;
  logic                    pend_vld;

  logic [3:0]              bin_r;
  logic                    dp_n_r;
  logic [NUM_DIGITS-1:0]   an_n_r;
  logic                    frame_done_r;

  always_comb begin
    cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    idx_nxt   = idx;
    if (cnt == CNT_LAST) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
    frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
    an_show   = '1;
    an_show[idx] = ~disp_en[idx];
  end

  // Phase register tracks which side of the blanking boundary cnt sits on,
  // so the output stage only looks at a flop instead of a magnitude compare.
  if (BLANK == 0) begin : g_noblank
    assign nxt_blank = 1'b0;
  end else begin : g_blank
    assign nxt_blank = (cnt_nxt < CNT_W'(BLANK));
  end

  // ---- scan stage: counters, phase FSM and registered display outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      phase        <= PH_RST;
      bin_r        <= '0;
      dp_n_r       <= 1'b1;
      an_n_r       <= '1;
      frame_done_r <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      phase        <= nxt_blank ? PH_BLANK : PH_SHOW;
      frame_done_r <= frame_end;
      // bin_out only moves at slot start: idx and the display regs are stable mid-slot.
      bin_r        <= disp_dig[{idx, 2'b00} +: 4];
      case (phase)
        PH_BLANK: begin
          an_n_r <= '1;
          dp_n_r <= 1'b1;
        end
        PH_SHOW: begin
          an_n_r <= an_show;
          dp_n_r <= ~(disp_dp[idx] & disp_en[idx]);
        end
        default: begin
          an_n_r <= '1;
          dp_n_r <= 1'b1;
        end
      endcase
    end
  end

  // ---- load / commit stage: pending regs swap into display at frame end ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_en  <= '1;
      disp_dig <= '0;
      disp_dp  <= '0;
      disp_en  <= '1;
      pend_vld <= 1'b0;
    end else begin
      // A commit reads the pending regs before a same-cycle load overwrites them.
      if (frame_end && pend_vld) begin
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
        disp_en  <= pend_en;
      end
      if (bus.load) begin
        pend_dig <= bus.digits_in;
        pend_dp  <= bus.dp_in;
        pend_en  <= bus.en_in;
      end
      pend_vld <= bus.load | (pend_vld & ~frame_end);
    end
  end

  assign bus.bin_out    = bin_r;
  assign bus.dp_n       = dp_n_r;
  assign bus.an_n       = an_n_r;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_r;
  assign bus.pending    = pend_vld;

endmodule
